// File: rtl/counter_pkg.sv
// Shared types for the counter bank and its readout path.
package counter_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } readout_state_e;

endpackage

// File: rtl/counter_readout_if.sv
// Valid/ready beat channel carrying one lane value and its lane index.
interface counter_readout_if
  import counter_pkg::*;
#(
  parameter int unsigned IDX_W = 1
) ();

  logic             valid;
  logic             ready;
  cnt_t             data;
  logic [IDX_W-1:0] index;
  logic             last;

  modport master (output valid, output data, output index, output last, input ready);
  modport slave  (input valid, input data, input index, input last, output ready);

endinterface

// File: rtl/counter_readout.sv
// Walks the counter lanes one per beat, streams them out and reports sum/XOR per scan.
module counter_readout
  import counter_pkg::*;
#(
  parameter int unsigned N     = 1000,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned SUM_W = CNT_W + $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  cnt_t               cnt [0:N-1],
  input  logic               start,
  output logic               busy,
  counter_readout_if.master  out,
  output logic [SUM_W-1:0]   sum_q,
  output cnt_t               xor_q,
  output logic               done
);

  // idx is one bit wider than a lane index so it can reach N (all lanes issued).
  localparam int unsigned IW = IDX_W + 1;
  localparam logic [IDX_W:0] NLanes  = IW'(N);
  localparam logic [IDX_W:0] LastIdx = IW'(N - 1);

  readout_state_e   state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  cnt_t             acc_xor_q, acc_xor_d;
  logic             valid_q, valid_d;
  cnt_t             data_q, data_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             last_q, last_d;
  logic [SUM_W-1:0] sum_d;
  cnt_t             xor_d;
  cnt_t             lane;
  logic             load;

  assign lane = cnt[idx_q[IDX_W-1:0]];
  assign load = !valid_q || out.ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_sum_d = acc_sum_q;
    acc_xor_d = acc_xor_q;
    valid_d   = valid_q;
    data_d    = data_q;
    index_d   = index_q;
    last_d    = last_q;
    sum_d     = sum_q;
    xor_d     = xor_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d     = '0;
          acc_sum_d = '0;
          acc_xor_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (load) begin
          if (idx_q < NLanes) begin
            data_d    = lane;
            index_d   = idx_q[IDX_W-1:0];
            last_d    = (idx_q == LastIdx);
            valid_d   = 1'b1;
            idx_d     = idx_q + 1'b1;
            acc_sum_d = acc_sum_q + SUM_W'(lane);
            acc_xor_d = acc_xor_q ^ lane;
          end else begin
            valid_d = 1'b0;
            // Results are published on the edge entering FINISH so done and the
            // new totals are visible together while start is still blocked.
            if (valid_q && out.ready && last_q) begin
              sum_d   = acc_sum_q;
              xor_d   = acc_xor_q;
              state_d = FINISH;
            end
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_sum_q <= '0;
      acc_xor_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
      sum_q     <= '0;
      xor_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_sum_q <= acc_sum_d;
      acc_xor_q <= acc_xor_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      index_q   <= index_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      xor_q     <= xor_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign out.valid = valid_q;
  assign out.data  = data_q;
  assign out.index = index_q;
  assign out.last  = last_q;

endmodule

// File: tb/tb_counter_readout.sv
// Directed bench for counter_readout: N=4 main instance plus an N=1 build.
module tb_counter_readout;
  import counter_pkg::*;

  localparam logic [33:0] SumRef = 34'h1_0000_0014;
  localparam logic [31:0] XorRef = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt [0:3];
  logic        start;
  logic        busy;
  logic [33:0] sum;
  logic [31:0] xr;
  logic        done;

  logic [31:0] cnt1 [0:0];
  logic        start1;
  logic        busy1;
  logic [31:0] sum1;
  logic [31:0] xr1;
  logic        done1;

  counter_readout_if #(.IDX_W(2)) bus ();
  counter_readout_if #(.IDX_W(1)) bus1 ();

  counter_readout #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .cnt   (cnt),
    .start (start),
    .busy  (busy),
    .out   (bus),
    .sum_q (sum),
    .xor_q (xr),
    .done  (done)
  );

  counter_readout #(.N(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .cnt   (cnt1),
    .start (start1),
    .busy  (busy1),
    .out   (bus1),
    .sum_q (sum1),
    .xor_q (xr1),
    .done  (done1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic [1:0]  index;
    logic        last;
    logic        busy;
    logic        done;
    logic [33:0] sum;
    logic [31:0] xr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic v, input logic [31:0] d,
                              input logic [1:0] i, input logic l, input logic b,
                              input logic dn, input logic [33:0] sm, input logic [31:0] x);
    vec_t t;
    t.start = s; t.ready = r; t.valid = v; t.data = d; t.index = i;
    t.last = l; t.busy = b; t.done = dn; t.sum = sm; t.xr = x;
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    int          beats;
    bit          done_seen;
    logic [33:0] exp_sum;
    logic [31:0] exp_xor;

    // Scan 1: ready held high; start pulsed mid-scan and on the done cycle.
    tbl[0]  = mk(1, 1, 0, 0,            0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 32'd5,        0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 32'd7,        1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 32'd9,        2, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 32'hFFFFFFFF, 3, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0,            0, 0, 1, 1, SumRef, XorRef);
    tbl[6]  = mk(1, 1, 0, 0,            0, 0, 0, 0, SumRef, XorRef);
    // Scan 2: start one cycle after done, then backpressure on beat 1.
    tbl[7]  = mk(1, 1, 0, 0,            0, 0, 1, 0, SumRef, XorRef);
    tbl[8]  = mk(0, 1, 1, 32'd5,        0, 0, 1, 0, SumRef, XorRef);
    tbl[9]  = mk(0, 1, 1, 32'd7,        1, 0, 1, 0, SumRef, XorRef);
    tbl[10] = mk(0, 0, 1, 32'd7,        1, 0, 1, 0, SumRef, XorRef);
    tbl[11] = mk(0, 0, 1, 32'd7,        1, 0, 1, 0, SumRef, XorRef);
    tbl[12] = mk(0, 0, 1, 32'd7,        1, 0, 1, 0, SumRef, XorRef);
    tbl[13] = mk(0, 1, 1, 32'd9,        2, 0, 1, 0, SumRef, XorRef);
    tbl[14] = mk(0, 1, 1, 32'hFFFFFFFF, 3, 1, 1, 0, SumRef, XorRef);
    tbl[15] = mk(0, 1, 0, 0,            0, 0, 1, 1, SumRef, XorRef);
    tbl[16] = mk(0, 1, 0, 0,            0, 0, 0, 0, SumRef, XorRef);

    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    bus.ready = 1'b1;
    bus1.ready = 1'b1;
    cnt[0] = 32'd5; cnt[1] = 32'd7; cnt[2] = 32'd9; cnt[3] = 32'hFFFFFFFF;
    cnt1[0] = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_valid", bus.valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_xor", xr, 0);
    chk("reset_data", bus.data, 0);

    for (int r = 0; r < 17; r++) begin
      start = tbl[r].start;
      bus.ready = tbl[r].ready;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", r), bus.valid, tbl[r].valid);
      chk($sformatf("row%0d_busy", r), busy, tbl[r].busy);
      chk($sformatf("row%0d_done", r), done, tbl[r].done);
      chk($sformatf("row%0d_sum", r), sum, tbl[r].sum);
      chk($sformatf("row%0d_xor", r), xr, tbl[r].xr);
      if (tbl[r].valid) begin
        chk($sformatf("row%0d_data", r), bus.data, tbl[r].data);
        chk($sformatf("row%0d_index", r), bus.index, tbl[r].index);
        chk($sformatf("row%0d_last", r), bus.last, tbl[r].last);
      end
    end
    start = 1'b0;
    bus.ready = 1'b1;

    // Reset after beat 2 is on the bus: scan aborts and totals clear.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.valid && bus.index == 2'd2) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("abort_reached_beat2", done_seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", bus.valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_xor", xr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full scan after the abort.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    beats = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        chk($sformatf("rescan_index%0d", beats), bus.index, beats);
        chk($sformatf("rescan_data%0d", beats), bus.data, cnt[beats & 3]);
        beats++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
    end
    chk("rescan_beats", beats, 4);
    chk("rescan_done", done_seen, 1);
    chk("rescan_sum", sum, SumRef);
    chk("rescan_xor", xr, XorRef);
    @(posedge clk);
    #1;

    // Live counters: lane i starts at 100*i and every lane increments each cycle.
    for (int i = 0; i < 4; i++) cnt[i] = 32'(100 * i);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = cnt[i] + 1;
    beats = 0;
    done_seen = 1'b0;
    exp_sum = '0;
    exp_xor = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        // The beat was loaded from the values present just before this edge.
        chk($sformatf("live_index%0d", beats), bus.index, beats);
        chk($sformatf("live_data%0d", beats), bus.data, cnt[beats & 3]);
        exp_sum = exp_sum + 34'(cnt[beats & 3]);
        exp_xor = exp_xor ^ cnt[beats & 3];
        beats++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      for (int i = 0; i < 4; i++) cnt[i] = cnt[i] + 1;
    end
    chk("live_beats", beats, 4);
    chk("live_done", done_seen, 1);
    chk("live_sum", sum, exp_sum);
    chk("live_xor", xr, exp_xor);

    // N=1 build: single beat that is also the last.
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    beats = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus1.valid) begin
        chk("n1_data", bus1.data, 32'hA5A5A5A5);
        chk("n1_index", bus1.index, 0);
        chk("n1_last", bus1.last, 1);
        beats++;
      end
      if (done1) begin
        done_seen = 1'b1;
        break;
      end
    end
    chk("n1_beats", beats, 1);
    chk("n1_done", done_seen, 1);
    chk("n1_sum", sum1, 32'hA5A5A5A5);
    chk("n1_xor", xr1, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    chk("n1_done_pulse", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
